ring_decoder_monitor: RTL and testbench

- Receive-side companion to the one-hot ring counter.
- Samples an N-bit ring code, decodes it to a binary index, and checks one-hot legality and the left-rotation step (bit i -> bit i+1 mod N).
- Acquires and holds lock on the sequence; reports errors for downstream sequencing and diagnostic logic.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_onehot_enc.sv | 23 ++
 rtl/ring_decoder_monitor.sv | 158 +++++++++++++++
 tb/tb_ring_decoder_monitor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring counter / ring decoder pair: FSM state
// encodings, index-width helper and the rotate-left position mapping.
package ring_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } ring_state_e;

  // Minimum width used for a binary ring index.
  localparam int unsigned MinIdxW = 1;

  // Width of a binary index addressing n ring positions (never below MinIdxW).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : MinIdxW;
  endfunction

  // Destination position of bit i after one left rotation of an n-bit ring.
  function automatic int unsigned rotl_pos(input int unsigned i, input int unsigned n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational ring-code decoder: flags one-hot codes and reports the
// binary position of the set bit.
module ring_onehot_enc #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    code,
  output logic [IdxW-1:0] idx,
  output logic            is_onehot
);

  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign is_onehot = (code != '0) && ((code & (code - N'(1))) == '0);

  // OR of set-bit positions; exact whenever the code is one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) idx = idx | IdxW'(i);
    end
  end

endmodule

// File: rtl/ring_decoder_monitor.sv
// Ring decoder / sequence monitor: decodes a sampled one-hot ring code,
// tracks lock on the left-rotation sequence and reports errors.
// Optional saturating error counter enabled by defining RING_DEC_ERR_CNT_EN;
// otherwise err_count is tied to zero.
module ring_decoder_monitor
  import ring_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N-1:0]            ring_in,
  output logic [idx_width(N)-1:0] idx,
  output logic                    idx_valid,
  output logic                    locked,
  output logic                    onehot_err,
  output logic                    seq_err,
  output logic                    wrap,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int unsigned IdxW  = idx_width(N);
  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);

  ring_state_e     state_q, state_d;
  logic [N-1:0]    prev_q, prev_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            idx_valid_q, idx_valid_d;
  logic            onehot_err_q, onehot_err_d;
  logic            seq_err_q, seq_err_d;
  logic            wrap_q, wrap_d;

  logic [IdxW-1:0] enc_idx;
  logic            enc_onehot;
  logic [N-1:0]    expected;
  logic            step_ok;

  ring_onehot_enc #(
    .N    (N),
    .IdxW (IdxW)
  ) u_enc (
    .code      (ring_in),
    .idx       (enc_idx),
    .is_onehot (enc_onehot)
  );

  // Expected next code is the previous sample rotated left by one.
  for (genvar g = 0; g < N; g++) begin : g_rot
    assign expected[rotl_pos(g, N)] = prev_q[g];
  end

  // A stuck code never equals its own rotation, so it fails this test too.
  assign step_ok = (ring_in == expected);

  // Next-state, prev/index tracking and error pulse generation.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_d       = good_q;
    idx_d        = idx_q;
    idx_valid_d  = idx_valid_q;
    onehot_err_d = 1'b0;
    seq_err_d    = 1'b0;
    wrap_d       = 1'b0;
    if (en) begin
      idx_valid_d = enc_onehot;
      if (!enc_onehot) begin
        onehot_err_d = 1'b1;
        state_d      = ST_UNLOCKED;
        good_d       = '0;
      end else begin
        idx_d  = enc_idx;
        prev_d = ring_in;
        case (state_q)
          ST_UNLOCKED: begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
          ST_ACQUIRE: begin
            if (!step_ok) begin
              good_d = '0;
            end else if (good_q == GoodW'(LOCK_COUNT - 1)) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GoodW'(1);
            end
          end
          ST_LOCKED: begin
            if (step_ok) begin
              wrap_d = prev_q[N-1];
            end else begin
              seq_err_d = 1'b1;
              state_d   = ST_ACQUIRE;
              good_d    = '0;
            end
          end
          default: begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
          end
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      prev_q       <= '0;
      good_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      onehot_err_q <= onehot_err_d;
      seq_err_q    <= seq_err_d;
      wrap_q       <= wrap_d;
    end
  end

`ifdef RING_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of error pulses; the two error sources never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if ((onehot_err_d || seq_err_d) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign locked     = (state_q == ST_LOCKED);
  assign onehot_err = onehot_err_q;
  assign seq_err    = seq_err_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_ring_decoder_monitor.sv
// Bench for ring_decoder_monitor: directed scenarios followed by random
// traffic, all checked against a position-based reference model.
module tb_ring_decoder_monitor;

  localparam int N  = 4;
  localparam int LC = 2;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  ring_in;
  logic [1:0]    idx;
  logic          idx_valid;
  logic          locked;
  logic          onehot_err;
  logic          seq_err;
  logic          wrap;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = unlocked, 1 = acquiring, 2 = locked;
  // previous sample held as a ring position.
  int m_mode, m_prev, m_good, m_idx, m_valid, m_oh, m_seq, m_wrap, m_err;

  ring_decoder_monitor #(
    .N          (N),
    .LOCK_COUNT (LC),
    .ERR_CNT_W  (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ring_in    (ring_in),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .locked     (locked),
    .onehot_err (onehot_err),
    .seq_err    (seq_err),
    .wrap       (wrap),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bump_err();
`ifdef RING_DEC_ERR_CNT_EN
    if (m_err < (1 << EW) - 1) m_err++;
`endif
  endtask

  task automatic model_step(input logic r, input logic e, input logic [N-1:0] code);
    int pos;
    m_oh   = 0;
    m_seq  = 0;
    m_wrap = 0;
    if (r) begin
      m_mode = 0; m_prev = 0; m_good = 0; m_idx = 0; m_valid = 0; m_err = 0;
      return;
    end
    if (!e) return;
    if ($countones(code) != 1) begin
      m_oh = 1; m_valid = 0; m_mode = 0; m_good = 0;
      bump_err();
      return;
    end
    pos = 0;
    for (int i = 0; i < N; i++) if (code[i]) pos = i;
    m_valid = 1;
    m_idx   = pos;
    case (m_mode)
      0: begin m_mode = 1; m_good = 0; end
      1: begin
        if (pos == (m_prev + 1) % N) begin
          m_good++;
          if (m_good == LC) begin m_mode = 2; m_good = 0; end
        end else begin
          m_good = 0;
        end
      end
      default: begin
        if (pos == (m_prev + 1) % N) begin
          if (m_prev == N - 1) m_wrap = 1;
        end else begin
          m_seq = 1; m_mode = 1; m_good = 0;
          bump_err();
        end
      end
    endcase
    m_prev = pos;
  endtask

  // Apply one cycle of stimulus, advance the model, check outputs 1ns later.
  task automatic cyc(input logic r, input logic e, input logic [N-1:0] code);
    rst = r; en = e; ring_in = code;
    @(posedge clk);
    model_step(r, e, code);
    #1;
    check_eq("idx",        32'(idx),        32'(m_idx));
    check_eq("idx_valid",  32'(idx_valid),  32'(m_valid));
    check_eq("locked",     32'(locked),     32'(m_mode == 2));
    check_eq("onehot_err", 32'(onehot_err), 32'(m_oh));
    check_eq("seq_err",    32'(seq_err),    32'(m_seq));
    check_eq("wrap",       32'(wrap),       32'(m_wrap));
    check_eq("err_count",  32'(err_count),  32'(m_err));
  endtask

  initial begin
    logic [N-1:0] last;
    logic [N-1:0] code;
    logic         r;
    logic         e;
    m_mode = 0; m_prev = 0; m_good = 0; m_idx = 0; m_valid = 0;
    m_oh = 0; m_seq = 0; m_wrap = 0; m_err = 0;

    // 1: reset then one full rotation plus wrap
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b1, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0010);
    check_eq("t1_not_locked_yet", 32'(locked), 32'd0);
    cyc(1'b0, 1'b1, 4'b0100);
    check_eq("t1_locked", 32'(locked), 32'd1);
    cyc(1'b0, 1'b1, 4'b1000);
    cyc(1'b0, 1'b1, 4'b0001);
    check_eq("t1_wrap", 32'(wrap), 32'd1);
    check_eq("t1_idx0", 32'(idx), 32'd0);

    // 2: locked at 0010, then an illegal two-hot code
    cyc(1'b0, 1'b1, 4'b0010);
    cyc(1'b0, 1'b1, 4'b0110);
    check_eq("t2_idx_hold", 32'(idx), 32'd1);
    check_eq("t2_onehot_err", 32'(onehot_err), 32'd1);

    // 3: relock, then a skipped step from 0001
    cyc(1'b0, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0010);
    cyc(1'b0, 1'b1, 4'b0100);
    cyc(1'b0, 1'b1, 4'b1000);
    cyc(1'b0, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0100);
    check_eq("t3_seq_err", 32'(seq_err), 32'd1);
    check_eq("t3_idx2", 32'(idx), 32'd2);
    cyc(1'b0, 1'b1, 4'b1000);
    cyc(1'b0, 1'b1, 4'b0001);
    check_eq("t3_relocked", 32'(locked), 32'd1);

    // 4: en low with garbage input holds everything
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'b1111);

    // 5: repeated all-zero codes drive the counter to saturation
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 4'b0000);

    // 6: reset while locked with two errors recorded
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0010);
    cyc(1'b0, 1'b1, 4'b0100);
    cyc(1'b1, 1'b1, 4'b1000);
    check_eq("t6_rst_locked", 32'(locked), 32'd0);
    check_eq("t6_rst_idx_valid", 32'(idx_valid), 32'd0);

    // Random traffic: mostly correct rotations, some stuck or random codes
    last = 4'b0001;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        0:       code = 4'($urandom);
        1:       code = last;
        default: code = {last[N-2:0], last[N-1]};
      endcase
      if (!r && e && $countones(code) == 1) last = code;
      cyc(r, e, code);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
